mem_arbiter: RTL and testbench

//  Shares the core's single-port synchronous RAM between the instruction-fetch port (I) and the

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the fetch (I)
// and load/store (D) ports; read data returns to its owner one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AW     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      i_ack,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_ack,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [DATA_WIDTH/8-1:0]   ram_be,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  // resp_owner | meaning
  // OWN_NONE   | no read data expected from the RAM this cycle
  // OWN_I      | ram_rdata this cycle belongs to the fetch port
  // OWN_D      | ram_rdata this cycle belongs to the load/store port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e                resp_owner, resp_owner_nxt;
  logic                  last_gnt_d, last_gnt_d_nxt;
  logic                  gnt_i, gnt_d;
  logic [DATA_WIDTH-1:0] i_hold, d_hold;

  // RAM is word addressed; byte offset and bits above the RAM size alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:RAM_AW+2], i_addr[1:0],
                              d_addr[ADDR_WIDTH-1:RAM_AW+2], d_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_owner <= OWN_NONE;
      last_gnt_d <= 1'b0;
      i_hold     <= '0;
      d_hold     <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      last_gnt_d <= last_gnt_d_nxt;
      if (resp_owner == OWN_I) i_hold <= ram_rdata;
      if (resp_owner == OWN_D) d_hold <= ram_rdata;
    end
  end

  always_comb begin
    gnt_i          = 1'b0;
    gnt_d          = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_be         = '0;
    ram_addr       = '0;
    ram_wdata      = '0;
    resp_owner_nxt = OWN_NONE;
    last_gnt_d_nxt = last_gnt_d;

    // Gating on reset keeps every combinational output low while reset is held.
    if (reset) begin
      if (d_req && (!i_req || !last_gnt_d)) gnt_d = 1'b1;
      else if (i_req)                       gnt_i = 1'b1;
    end

    if (gnt_i) begin
      ram_en         = 1'b1;
      ram_be         = '1;
      ram_addr       = i_addr[RAM_AW+1:2];
      resp_owner_nxt = OWN_I;
      last_gnt_d_nxt = 1'b0;
    end else if (gnt_d) begin
      ram_en         = 1'b1;
      ram_we         = d_we;
      ram_be         = d_be;
      ram_addr       = d_addr[RAM_AW+1:2];
      ram_wdata      = d_wdata;
      resp_owner_nxt = d_we ? OWN_NONE : OWN_D;
      last_gnt_d_nxt = 1'b1;
    end
  end

  assign i_ack    = gnt_i;
  assign d_ack    = gnt_d;
  assign i_rvalid = (resp_owner == OWN_I);
  assign d_rvalid = (resp_owner == OWN_D);
  assign i_rdata  = i_rvalid ? ram_rdata : i_hold;
  assign d_rdata  = d_rvalid ? ram_rdata : d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: behavioural RAM, reference grant/memory model,
// and a tagged scoreboard checked by an independent response monitor.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_ack, i_rvalid, d_ack, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM driven by the DUT
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(posedge clk) cyc++;

  // Reference model: architectural memory plus round-robin owner
  typedef struct { int unsigned tag; logic [31:0] data; } exp_t;
  exp_t        iq[$], dq[$];
  logic [31:0] ref_mem [4096];
  logic        model_last_d;

  always @(negedge clk) begin
    logic ei, ed;
    if (!reset) begin
      model_last_d = 1'b0;
      iq.delete();
      dq.delete();
      chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
      chk("rst_ram", {25'd0, ram_en, ram_we, ram_be, 1'b0} | {20'd0, ram_addr}, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
      chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    end else begin
      ed = d_req && (!i_req || !model_last_d);
      ei = i_req && !ed;
      chk("acks", {30'd0, i_ack, d_ack}, {30'd0, ei, ed});
      if (ei) begin
        chk("i_ram", {19'd0, ram_en, ram_we, ram_be, 1'b0, 6'd0} | {20'd0, ram_addr},
            {19'd0, 1'b1, 1'b0, 4'hF, 1'b0, 6'd0} | {20'd0, i_addr[13:2]});
        iq.push_back('{cyc, ref_mem[i_addr[13:2]]});
        model_last_d = 1'b0;
      end else if (ed) begin
        chk("d_ram", {19'd0, ram_en, ram_we, ram_be, 1'b0, 6'd0} | {20'd0, ram_addr},
            {19'd0, 1'b1, d_we, d_be, 1'b0, 6'd0} | {20'd0, d_addr[13:2]});
        if (d_we) begin
          chk("d_wdata", ram_wdata, d_wdata);
          ref_mem[d_addr[13:2]] = merge(ref_mem[d_addr[13:2]], d_wdata, d_be);
        end else begin
          dq.push_back('{cyc, ref_mem[d_addr[13:2]]});
        end
        model_last_d = 1'b1;
      end else begin
        chk("idle_ram", {25'd0, ram_en, ram_we, ram_be, 1'b0} | {20'd0, ram_addr}, 32'd0);
      end
    end
  end

  // Response monitor: pops entries issued exactly one cycle earlier
  logic [31:0] hold_i, hold_d;
  always @(negedge clk) begin
    logic v;
    exp_t e;
    if (!reset) begin
      hold_i = '0;
      hold_d = '0;
    end else begin
      v = (iq.size() > 0) && (iq[0].tag == cyc - 1);
      chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, v});
      if (v) begin
        e = iq.pop_front();
        chk("i_rdata", i_rdata, e.data);
        hold_i = e.data;
      end else chk("i_hold", i_rdata, hold_i);
      v = (dq.size() > 0) && (dq[0].tag == cyc - 1);
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, v});
      if (v) begin
        e = dq.pop_front();
        chk("d_rdata", d_rdata, e.data);
        hold_d = e.data;
      end else chk("d_hold", d_rdata, hold_d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic dreq(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a = $urandom;
    a[13:7] = '0;
    return a;
  endfunction

  initial begin
    logic ia, da;
    for (int k = 0; k < 4096; k++) begin
      mem[k] = $urandom;
      ref_mem[k] = mem[k];
    end
    mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    ram_rdata = '0;

    // Reset with both ports requesting
    reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    reset = 1'b1;

    // Single fetch, then hold check
    i_req = 1'b1; i_addr = 32'h10;
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("fetch_hold", i_rdata, 32'h00500093);
    step();

    // Contention for 6 cycles
    i_req = 1'b1; i_addr = 32'h104;
    dreq(1'b0, 4'h0, 32'h100, 32'h0);
    repeat (6) step();
    idle();
    repeat (2) step();

    // Byte write then read-back
    dreq(1'b1, 4'b0010, 32'h20, 32'hAABBCCDD);
    step();
    dreq(1'b0, 4'h0, 32'h20, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("bytewr_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("bytewr_data", d_rdata, 32'h1122CC44);
    step();

    // Back-to-back reads
    dreq(1'b0, 4'h0, 32'h0, 32'h0); step();
    dreq(1'b0, 4'h0, 32'h4, 32'h0); step();
    dreq(1'b0, 4'h0, 32'h8, 32'h0); step();
    idle();
    repeat (4) step();

    // Reset between a fetch grant and its response
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    #1;
    reset = 1'b0;
    i_req = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();

    // Randomised traffic with cancellations and aliased upper address bits
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ia = i_ack;
      da = d_ack;
      @(posedge clk);
      #1;
      if (ia || !i_req) begin
        i_req = ($urandom_range(0, 9) < 6);
        i_addr = rand_addr();
      end else if ($urandom_range(0, 19) == 0) i_req = 1'b0;
      if (da || !d_req) begin
        d_req = ($urandom_range(0, 9) < 6);
        d_we = $urandom_range(0, 1);
        d_be = $urandom;
        d_addr = rand_addr();
        d_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) d_req = 1'b0;
    end
    idle();
    repeat (3) step();
    chk("drain_i", iq.size(), 32'd0);
    chk("drain_d", dq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
